// File: rtl/usb_crc_pkg.sv
// Shared constants, FSM encoding and serial CRC step for the USB CRC16 paths.
package usb_crc_pkg;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_PRESET   = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic di);
      logic fb;
      fb = di ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/usb_crc16_core.sv
// Serial USB CRC16 register: optional preset, then one bit per enabled cycle.
module usb_crc16_core
   import usb_crc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic        di,
   output logic [15:0] crc,
   output logic [15:0] crc_next
);

   logic [15:0] base;

   // Preset takes effect before a same-cycle bit so that bit becomes bit 0.
   always_comb begin
      base     = init ? CRC16_PRESET : crc;
      crc_next = en ? crc16_step(base, di) : base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc <= CRC16_PRESET;
      end else begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/usb_crc16_rx.sv
// USB data-field receiver: CRC16 check, byte deserializer and 2-byte hold
// buffer that strips the trailing CRC bytes before they reach the payload FIFO.
module usb_crc16_rx
   import usb_crc_pkg::*;
#(
   parameter int MAX_BYTES = 1026
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_start,
   input  logic        crc16_di,
   input  logic        crc16_en,
   input  logic        pkt_end,
   output logic [15:0] crc16_o,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_busy,
   output logic        chk_done,
   output logic        chk_ok,
   output logic        err_crc,
   output logic        err_align,
   output logic        err_short,
   output logic        err_long
);

   localparam int CNT_W = $clog2(MAX_BYTES + 1);
   localparam logic [CNT_W-1:0] BYTE_MAX = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] BYTE_SAT = CNT_W'(MAX_BYTES + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == BYTE_SAT) ? v : v + CNT_W'(1);
   endfunction

   state_t           state, state_nx;
   logic             accept, byte_done, emit, check;
   logic [15:0]      crc_nx;
   logic [2:0]       bit_cnt, bit_base, bit_nx;
   logic [CNT_W-1:0] byte_cnt, byte_base, byte_nx;
   logic [1:0]       fill, fill_base, fill_nx;
   logic [7:0]       shreg, shreg_nx;
   logic [7:0]       hold0, hold0_nx, hold1, hold1_nx;
   logic             f_crc, f_align, f_short, f_long;

   // A bit is taken in RUN, or in any state when it coincides with pkt_start.
   assign accept = crc16_en && (pkt_start || (state == RUN));
   assign check  = pkt_end && (state == RUN) && !pkt_start;

   usb_crc16_core u_core (
      .clk      (clk),
      .reset    (reset),
      .init     (pkt_start),
      .en       (accept),
      .di       (crc16_di),
      .crc      (crc16_o),
      .crc_next (crc_nx)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pkt_start) state_nx = RUN;
         RUN:     if (!pkt_start && pkt_end) state_nx = DONE;
         DONE:    state_nx = pkt_start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Counters restart from zero on pkt_start before the same-cycle bit lands.
   always_comb begin
      bit_base  = pkt_start ? 3'd0 : bit_cnt;
      byte_base = pkt_start ? '0 : byte_cnt;
      fill_base = pkt_start ? 2'd0 : fill;

      shreg_nx = shreg;
      if (accept) shreg_nx[bit_base] = crc16_di;

      byte_done = accept && (bit_base == 3'd7);
      bit_nx    = accept ? bit_base + 3'd1 : bit_base;
      byte_nx   = byte_done ? sat_inc(byte_base) : byte_base;

      emit     = byte_done && (fill_base == 2'd2);
      fill_nx  = fill_base;
      hold0_nx = hold0;
      hold1_nx = hold1;
      if (byte_done) begin
         case (fill_base)
            2'd0: begin
               hold0_nx = shreg_nx;
               fill_nx  = 2'd1;
            end
            2'd1: begin
               hold1_nx = shreg_nx;
               fill_nx  = 2'd2;
            end
            default: begin
               hold0_nx = hold1;
               hold1_nx = shreg_nx;
            end
         endcase
      end

      f_crc   = (crc_nx != CRC16_RESIDUAL);
      f_align = (bit_nx != 3'd0);
      f_short = (byte_nx < CNT_W'(2));
      f_long  = (byte_nx > BYTE_MAX);
   end

   // Data path: shift and hold registers need no reset, contents are
   // always written before they are observed.
   always_ff @(posedge clk) begin
      shreg <= shreg_nx;
      hold0 <= hold0_nx;
      hold1 <= hold1_nx;
   end

   // Control and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         byte_cnt  <= '0;
         fill      <= 2'd0;
         rx_data   <= 8'd0;
         rx_valid  <= 1'b0;
         chk_done  <= 1'b0;
         chk_ok    <= 1'b0;
         err_crc   <= 1'b0;
         err_align <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= bit_nx;
         byte_cnt <= byte_nx;
         fill     <= fill_nx;
         rx_valid <= emit;
         if (emit) rx_data <= hold0;
         chk_done <= check;
         if (check) begin
            err_crc   <= f_crc;
            err_align <= f_align;
            err_short <= f_short;
            err_long  <= f_long;
            chk_ok    <= !(f_crc || f_align || f_short || f_long);
         end
      end
   end

   assign rx_busy = (state == RUN);

endmodule

// File: tb/tb_usb_crc16_rx.sv
// Bench for usb_crc16_rx: table of packets plus randomized packets, all
// compared against a bit-stream model of CRC, framing and emitted payload.
module tb_usb_crc16_rx;

   localparam int MAXB = 1026;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pkt_start = 1'b0;
   logic        crc16_di = 1'b0;
   logic        crc16_en = 1'b0;
   logic        pkt_end = 1'b0;
   logic [15:0] crc16_o;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_busy, chk_done, chk_ok;
   logic        err_crc, err_align, err_short, err_long;

   usb_crc16_rx #(.MAX_BYTES(MAXB)) dut (
      .clk(clk), .reset(reset), .pkt_start(pkt_start), .crc16_di(crc16_di),
      .crc16_en(crc16_en), .pkt_end(pkt_end), .crc16_o(crc16_o),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
      .chk_done(chk_done), .chk_ok(chk_ok), .err_crc(err_crc),
      .err_align(err_align), .err_short(err_short), .err_long(err_long)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         stim_q[$];
   logic [7:0] got_q[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic [4:0] st_flags = '0;
   logic       st_busy = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (chk_done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         st_flags = {chk_ok, err_crc, err_align, err_short, err_long};
         st_busy  = rx_busy;
      end
   end

   typedef struct {
      int         n_pay;
      int         pat;
      bit         add_crc;
      int         flip;
      int         extra;
      bit         co_s;
      bit         co_e;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      done_cnt = 0;
      got_q.delete();
   endtask

   // Remainder of the first n stream bits under x^16+x^15+x^2+1, preset all-ones.
   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         if (r[15] ^ stim_q[i]) r = (r << 1) ^ 16'h8005;
         else                   r = r << 1;
      end
      return r;
   endfunction

   function automatic logic [4:0] model_flags();
      int  n    = stim_q.size();
      int  full = n / 8;
      bit  e_crc   = (model_crc(n) != 16'h800D);
      bit  e_align = (n % 8) != 0;
      bit  e_short = full < 2;
      bit  e_long  = full > MAXB;
      return {!(e_crc || e_align || e_short || e_long), e_crc, e_align, e_short, e_long};
   endfunction

   task automatic build(input int n_pay, input int pat, input bit add_crc,
                        input int flip, input int extra, input bit rnd_extra);
      logic [7:0]  b;
      logic [15:0] c;
      stim_q.delete();
      for (int i = 0; i < n_pay; i++) begin
         if (pat == 0)      b = 8'(i);
         else if (pat == 1) b = 8'($urandom);
         else               b = 8'd0;
         for (int k = 0; k < 8; k++) stim_q.push_back(b[k]);
      end
      if (add_crc) begin
         c = ~model_crc(stim_q.size());
         for (int k = 15; k >= 0; k--) stim_q.push_back(c[k]);
      end
      if (flip >= 0 && flip < stim_q.size()) stim_q[flip] = !stim_q[flip];
      for (int e = 0; e < extra; e++) stim_q.push_back(rnd_extra ? 1'($urandom) : 1'b0);
   endtask

   task automatic send(input bit co_s, input bit co_e, input bit gaps, output int end_cyc);
      int n = stim_q.size();
      int i = 0;
      int last;
      pkt_start = 1'b1;
      if (co_s && n > 0) begin
         crc16_en = 1'b1;
         crc16_di = stim_q[0];
         i = 1;
      end
      @(negedge clk);
      pkt_start = 1'b0;
      crc16_en  = 1'b0;
      last = (co_e && n > i) ? n - 1 : n;
      while (i < last) begin
         if (gaps && ($urandom % 4 == 0)) begin
            crc16_en = 1'b0;
            crc16_di = 1'($urandom);
            @(negedge clk);
         end
         crc16_en = 1'b1;
         crc16_di = stim_q[i];
         i++;
         @(negedge clk);
      end
      crc16_en = 1'b0;
      pkt_end  = 1'b1;
      if (i < n) begin
         crc16_en = 1'b1;
         crc16_di = stim_q[i];
      end
      end_cyc = cyc;
      @(negedge clk);
      pkt_end  = 1'b0;
      crc16_en = 1'b0;
   endtask

   task automatic run_check(input logic [4:0] exp, input bit co_s, input bit co_e,
                            input bit gaps, input string id);
      int          n = stim_q.size();
      int          full = n / 8;
      int          n_emit = (full >= 2) ? full - 2 : 0;
      logic [15:0] mc = model_crc(n);
      int          end_cyc;
      int          bad = 0;
      logic [7:0]  e;
      send(co_s, co_e, gaps, end_cyc);
      repeat (4) @(negedge clk);
      chk({id, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({id, "_done_lat"}, 32'(done_cyc - end_cyc), 32'd1);
      chk({id, "_flags"}, 32'(st_flags), 32'(exp));
      chk({id, "_busy_at_done"}, 32'(st_busy), 32'd0);
      chk({id, "_nbytes"}, 32'(got_q.size()), 32'(n_emit));
      for (int j = 0; j < n_emit && j < got_q.size(); j++) begin
         for (int k = 0; k < 8; k++) e[k] = stim_q[8 * j + k];
         if (got_q[j] !== e) bad++;
      end
      chk({id, "_bytes_bad"}, 32'(bad), 32'd0);
      chk({id, "_crc16_o"}, 32'(crc16_o), 32'(mc));
   endtask

   initial begin
      tbl[0] = '{0,        0, 1'b1, -1, 0, 1'b0, 1'b0, 5'b10000};
      tbl[1] = '{4,        0, 1'b1, -1, 0, 1'b0, 1'b0, 5'b10000};
      tbl[2] = '{4,        0, 1'b1,  5, 0, 1'b0, 1'b0, 5'b01000};
      tbl[3] = '{0,        0, 1'b1, -1, 3, 1'b0, 1'b0, 5'b01100};
      tbl[4] = '{0,        0, 1'b0, -1, 8, 1'b0, 1'b0, 5'b01010};
      tbl[5] = '{MAXB - 1, 1, 1'b1, -1, 0, 1'b0, 1'b0, 5'b00001};
      tbl[6] = '{MAXB - 2, 1, 1'b1, -1, 0, 1'b0, 1'b0, 5'b10000};
      tbl[7] = '{0,        0, 1'b1, -1, 0, 1'b1, 1'b1, 5'b10000};
      tbl[8] = '{4,        1, 1'b1, -1, 0, 1'b1, 1'b1, 5'b10000};
      tbl[9] = '{1,        1, 1'b1, -1, 0, 1'b1, 1'b0, 5'b10000};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_crc16_o", 32'(crc16_o), 32'hFFFF);
      chk("rst_outputs", 32'({rx_data, rx_valid, rx_busy, chk_done, chk_ok,
                              err_crc, err_align, err_short, err_long}), 32'd0);

      // Zero-length packet with explicit residual check
      build(0, 0, 1'b1, -1, 0, 1'b0);
      clear_mon();
      run_check(5'b10000, 1'b0, 1'b0, 1'b0, "zlp");
      chk("zlp_residual", 32'(crc16_o), 32'h800D);

      for (int v = 0; v < 10; v++) begin
         build(tbl[v].n_pay, tbl[v].pat, tbl[v].add_crc, tbl[v].flip, tbl[v].extra, 1'b0);
         clear_mon();
         run_check(tbl[v].exp, tbl[v].co_s, tbl[v].co_e, 1'b0, $sformatf("v%0d", v));
      end

      for (int r = 0; r < 8; r++) begin
         int np = $urandom_range(0, 6);
         int fl = ($urandom % 3 == 0) ? $urandom_range(0, 8 * np + 15) : -1;
         build(np, 1, ($urandom % 4) != 0, fl, $urandom_range(0, 9), 1'b1);
         clear_mon();
         run_check(model_flags(), 1'($urandom), 1'($urandom), 1'b1, $sformatf("r%0d", r));
      end

      // pkt_end while idle must be ignored
      clear_mon();
      pkt_end = 1'b1;
      @(negedge clk);
      pkt_end = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_end_done", 32'(done_cnt), 32'd0);
      chk("idle_end_busy", 32'(rx_busy), 32'd0);

      // Abort a packet with pkt_start, then a clean zero-length packet
      clear_mon();
      pkt_start = 1'b1;
      @(negedge clk);
      pkt_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         crc16_en = 1'b1;
         crc16_di = 1'($urandom);
         @(negedge clk);
      end
      crc16_en = 1'b0;
      build(0, 0, 1'b1, -1, 0, 1'b0);
      run_check(5'b10000, 1'b0, 1'b0, 1'b0, "abort");

      // Leave error flags set, then reset in the middle of a packet
      build(0, 0, 1'b0, -1, 8, 1'b0);
      clear_mon();
      run_check(5'b01010, 1'b0, 1'b0, 1'b0, "pre_rst");
      clear_mon();
      pkt_start = 1'b1;
      @(negedge clk);
      pkt_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         crc16_en = 1'b1;
         crc16_di = 1'($urandom);
         @(negedge clk);
      end
      crc16_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_crc16_o", 32'(crc16_o), 32'hFFFF);
      chk("mid_rst_outputs", 32'({rx_data, rx_valid, rx_busy, chk_done, chk_ok,
                                  err_crc, err_align, err_short, err_long}), 32'd0);
      pkt_end = 1'b1;
      @(negedge clk);
      pkt_end = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
      chk("mid_rst_no_bytes", 32'(got_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
